// File: rtl/spi_prog_slave.sv
// spi_prog_slave: SPI mode-0 programming responder turning 0x01/0x02 command frames into 32-bit memory writes; define SPI_PROG_READBACK_EN to echo the last byte on miso.
module spi_prog_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_ADDR    = 8'h01,
  parameter logic [7:0]  CMD_DATA    = 8'h02,
  parameter logic [31:0] ADDR_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_dq, sclk_s, cs_s, mosi_s, rise;
  logic [7:0] sh_q, sh_d, byte_q, byte_d;
  logic [2:0] bc_q, bc_d;
  logic [1:0] cnt_q, cnt_d;
  logic stb_q, stb_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_dq & ~cs_s;
  // cs_n sync resets high so no phantom frame start follows reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_q <= '0;
      cs_q <= '1;
      mosi_q <= '0;
      sclk_dq <= 1'b0;
      sh_q <= '0;
      bc_q <= '0;
      byte_q <= '0;
      stb_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      state_q <= IDLE;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_dq <= sclk_s;
      sh_q <= sh_d;
      bc_q <= bc_d;
      byte_q <= byte_d;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
      state_q <= state_d;
    end
  always_comb begin
    sh_d = rise ? {sh_q[6:0], mosi_s} : sh_q;
    bc_d = cs_s ? 3'd0 : bc_q + {2'b0, rise};
    stb_d = rise && bc_q == 3'd7;
    byte_d = stb_d ? sh_d : byte_q;
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (stb_q) begin
        state_d = byte_q == CMD_ADDR ? ADDR : byte_q == CMD_DATA ? DATA : IDLE;
        err_d = err_q | (byte_q != CMD_ADDR && byte_q != CMD_DATA);
        cnt_d = 2'd0;
      end
      ADDR: if (stb_q) begin
        addr_d = {addr_q[23:0], byte_q};
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? IDLE : ADDR;
      end
      DATA: if (stb_q) begin
        data_d = {data_q[23:0], byte_q};
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? WRITE : DATA;
      end
      WRITE: begin
        err_d = err_q | stb_q;
        addr_d = mem_ready ? addr_q + ADDR_STEP : addr_q;
        state_d = mem_ready ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_we = state_q == WRITE;
    busy = state_q != IDLE;
  end
  assign mem_addr = addr_q;
  assign mem_wdata = data_q;
  assign err = err_q;
`ifdef SPI_PROG_READBACK_EN
  logic [7:0] tx_q;
  logic cs_dq, fall, cs_fall;
  assign fall = ~sclk_s & sclk_dq & ~cs_s;
  assign cs_fall = cs_dq & ~cs_s;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cs_dq <= 1'b1;
      tx_q <= '0;
    end else begin
      cs_dq <= cs_s;
      tx_q <= cs_fall ? byte_q : fall ? {tx_q[6:0], 1'b0} : tx_q;
    end
  assign miso = ~cs_s & tx_q[7];
`else
  assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_prog_slave.sv
// tb_spi_prog_slave: directed SPI frame sequences against hand-computed write requests.
module tb_spi_prog_slave;
  logic clk = 0, reset = 1, sclk = 0, cs_n = 1, mosi = 0, mem_ready = 1;
  logic miso, mem_we, busy, err;
  logic [31:0] mem_addr, mem_wdata, acc_addr = 0, acc_data = 0;
  logic [7:0] rx;
  int total = 0, bad = 0, acc = 0, acc0 = 0, n = 0;
  spi_prog_slave dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_we && mem_ready) begin
      acc <= acc + 1;
      acc_addr <= mem_addr;
      acc_data <= mem_wdata;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    cs_n = 0;
    #40;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #40 r[i] = miso;
      sclk = 1;
      #40 sclk = 0;
    end
    #40 cs_n = 1;
    #40;
  endtask
  task automatic sb(input logic [7:0] b);
    logic [7:0] d;
    send_byte(b, d);
  endtask
  task automatic do_reset;
    #3 reset = 1;
    #10 reset = 0;
    #7;
  endtask
  initial begin
    #20;
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_miso", miso, 0);
    reset = 0;
    #20;
    sb(8'h01); sb(8'h10); sb(8'h00); sb(8'h00); sb(8'h00);
    chk("aload_addr", mem_addr, 32'h1000_0000);
    chk("aload_busy", busy, 0);
    chk("aload_nowe", acc, 0);
    chk("aload_err", err, 0);
    acc0 = acc;
    sb(8'h02); sb(8'hDE); sb(8'hAD); sb(8'hBE); sb(8'hEF);
    chk("wr_count", acc - acc0, 1);
    chk("wr_addr", acc_addr, 32'h1000_0000);
    chk("wr_data", acc_data, 32'hDEAD_BEEF);
    chk("wr_addr_inc", mem_addr, 32'h1000_0004);
    chk("wr_busy", busy, 0);
    chk("wr_err", err, 0);
    mem_ready = 0;
    acc0 = acc;
    sb(8'h02); sb(8'hCA); sb(8'hFE); sb(8'hBA); sb(8'hBE);
    n = 0;
    while (!mem_we && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_we_rise", mem_we, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_we_hold", mem_we, 1);
      chk("bp_addr_hold", mem_addr, 32'h1000_0004);
      chk("bp_data_hold", mem_wdata, 32'hCAFE_BABE);
    end
    chk("bp_no_accept", acc - acc0, 0);
    sb(8'h77);
    repeat (4) @(negedge clk);
    chk("bp_byte_err", err, 1);
    chk("bp_still_we", mem_we, 1);
    chk("bp_data_kept", mem_wdata, 32'hCAFE_BABE);
    mem_ready = 1;
    repeat (3) @(negedge clk);
    chk("bp_accept_once", acc - acc0, 1);
    chk("bp_acc_addr", acc_addr, 32'h1000_0004);
    chk("bp_acc_data", acc_data, 32'hCAFE_BABE);
    chk("bp_we_fall", mem_we, 0);
    chk("bp_addr_inc", mem_addr, 32'h1000_0008);
    do_reset();
    chk("rst2_err", err, 0);
    sb(8'h55);
    chk("bad_err", err, 1);
    chk("bad_idle", busy, 0);
    cs_n = 0;
    #40;
    for (int i = 0; i < 5; i++) begin
      mosi = 1;
      #40 sclk = 1;
      #40 sclk = 0;
    end
    #40 cs_n = 1;
    #40;
    acc0 = acc;
    sb(8'h02); sb(8'h12); sb(8'h34); sb(8'h56); sb(8'h78);
    chk("part_count", acc - acc0, 1);
    chk("part_addr", acc_addr, 32'h0);
    chk("part_data", acc_data, 32'h1234_5678);
    chk("part_addr_inc", mem_addr, 32'h4);
    chk("part_err_sticky", err, 1);
    do_reset();
    sb(8'h01); sb(8'hFF); sb(8'hFF); sb(8'hFF); sb(8'hFC);
    chk("wrap_load", mem_addr, 32'hFFFF_FFFC);
    acc0 = acc;
    sb(8'h02); sb(8'h00); sb(8'h00); sb(8'h00); sb(8'h01);
    chk("wrap_count", acc - acc0, 1);
    chk("wrap_acc_addr", acc_addr, 32'hFFFF_FFFC);
    chk("wrap_addr", mem_addr, 32'h0);
    sb(8'h01); sb(8'hAB);
    chk("mid_busy", busy, 1);
    chk("mid_addr", mem_addr, 32'hAB);
    chk("mid_wdata", mem_wdata, 32'h1);
    #3 reset = 1;
    #1;
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_miso", miso, 0);
    #6 reset = 0;
    #10;
`ifdef SPI_PROG_READBACK_EN
    sb(8'hA5);
    send_byte(8'h3C, rx);
    chk("readback", rx, 8'hA5);
`endif
    chk("idle_miso", miso, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_prog_slave.md
Name: spi_prog_slave

Overview:
- SPI responder (mode 0) that receives the flash/instruction-memory programming stream sent by the SPI master, and turns it into 32-bit memory write requests.
- Command protocol: 0x01 + 4 address bytes, or 0x02 + 4 data bytes. Multi-byte fields are MSB first.
- Sits between the SPI pads and the instruction-memory write port, ahead of core reset release.
- All logic runs in the system clock domain; SCLK, CS_n and MOSI are oversampled.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi (minimum 2).
- CMD_ADDR, 8'h01, command byte that loads the address register.
- CMD_DATA, 8'h02, command byte that loads a data word and triggers a write.
- ADDR_STEP, 4, address post-increment after each completed write.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master; idle low; frequency ≤ clk/4.
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master.
- mem_addr  out  32  write address.
- mem_wdata  out  32  write data.
- mem_we  out  1  write request valid.
- mem_ready  in  1  write accepted (handshake completes when mem_we && mem_ready).
- busy  out  1  high while a command is partially received or a write is pending.
- err  out  1  sticky error: unknown command or overflow; cleared only by reset.

Behaviour:
Reset values:
- All outputs are 0.
- The FSM is in IDLE, the address register is 0, and the shift/bit counters are 0.

Input sampling and edge detection:
- sclk, cs_n and mosi each pass through SYNC_STAGES flops.
- A rising/falling SCLK edge is detected when the synchronized value differs from its one-cycle-delayed copy.
- Edges are ignored while synchronized cs_n is high.

Byte receive:
- On each detected SCLK rise with cs_n low, shift mosi into the LSB of an 8-bit shift register and increment a 3-bit bit counter.
- When the count wraps 7→0, a byte strobe pulses for one clk cycle.
- A rising cs_n clears the bit counter and discards any partial byte.
- The command FSM is not affected by cs_n; it persists across frames, because the master sends one byte per CS frame.

Command FSM (states IDLE, ADDR, DATA, WRITE):
- IDLE:
  - Byte == CMD_ADDR → ADDR, with byte counter = 0.
  - Byte == CMD_DATA → DATA.
  - Any other byte → set err, stay in IDLE.
- ADDR:
  - Each byte shifts into the address register: addr = {addr[23:0], byte}.
  - After the 4th byte → IDLE.
  - The new address is visible on mem_addr the cycle after the 4th byte strobe.
- DATA:
  - Each byte shifts into the data register the same way.
  - After the 4th byte → WRITE, and mem_we rises the cycle after the strobe.
- WRITE:
  - mem_addr and mem_wdata are held stable while mem_we is high.
  - On mem_we && mem_ready: mem_we falls the next cycle, addr += ADDR_STEP (modulo 2^32, wraps silently), and the FSM returns to IDLE.
  - A byte strobe arriving in WRITE sets err and the byte is dropped. The write completes normally.

busy:
- busy = (state != IDLE).

Latency:
- From the SCLK rising pin edge of the last data bit to mem_we high: SYNC_STAGES + 2 clk cycles.

Reset mid-operation:
- Reset returns everything to reset values immediately; any pending write is abandoned.

Optional Feature:
SPI_PROG_READBACK_EN
- Defined:
  - miso shifts out the most recently completed received byte, MSB first.
  - Load it into the TX register on cs_n falling (synchronized); drive bit 7 immediately.
  - Shift on each detected SCLK fall.
  - The master therefore sees in frame N+1 the byte it sent in frame N.
  - miso is 0 when cs_n is high.
- Undefined: miso is tied to 0 and no TX register exists.

Test Plan:
- Address load: frames 01, 10, 00, 00, 00 → mem_addr = 0x1000_0000, busy low afterward, no mem_we.
- Data write: then 02, DE, AD, BE, EF with mem_ready tied high → exactly one mem_we pulse, with mem_addr = 0x1000_0000, mem_wdata = 0xDEADBEEF. Afterward mem_addr = 0x1000_0004.
- Backpressure: mem_ready held low for 20 cycles after data → mem_we and outputs stable for all 20 cycles. Single accept when mem_ready rises; send a byte during the stall → err = 1.
- Bad command and partial byte:
  - Send 0x55 → err = 1, state IDLE.
  - Raise cs_n after 5 bits, then send a full 0x02 + 4 bytes → write occurs with correct data.
- Wrap and async reset:
  - Load address 0xFFFF_FFFC, write one word → mem_addr becomes 0x0000_0000.
  - Assert reset mid-ADDR → all outputs 0 within the same cycle.
- Readback (SPI_PROG_READBACK_EN): send 0xA5 then 0x3C → miso during the second frame shifts 1,0,1,0,0,1,0,1.
